// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-timing master for the VGA display path. A free-running pair of
// counters produces the pixel coordinate (counter_H, counter_V) for the frame
// buffer controller. That controller answers with a 1-bit colour after a
// fixed latency of PIPE_LAT cycles. Sync and blanking decodes pass through a
// PIPE_LAT-deep shift register so that hsync, vsync, display_on and rgb all
// leave the block aligned with the pixel data they describe.
//
// Ports
//   clk          in   pixel clock, one pixel per cycle
//   reset        in   asynchronous, active-low reset
//   colour       in   frame buffer pixel (0 = background, 1 = foreground)
//   fg_rgb[5:0]  in   foreground colour {R[1:0],G[1:0],B[1:0]}
//   bg_rgb[5:0]  in   background colour, same packing
//   counter_H    out  horizontal coordinate, 0..H_TOTAL-1 (registered)
//   counter_V    out  vertical coordinate, 0..V_TOTAL-1 (registered)
//   frame_start  out  one-cycle pulse when the counters wrap to (0,0)
//   hsync        out  active-low horizontal sync, pipeline-aligned
//   vsync        out  active-low vertical sync, pipeline-aligned
//   display_on   out  active-area flag, pipeline-aligned
//   rgb[5:0]     out  pixel colour, pipeline-aligned, 0 while blanked
//
// PIPE_LAT must lie in 1..8.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIPE_LAT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       colour,
   input  logic [5:0] fg_rgb,
   input  logic [5:0] bg_rgb,
   output logic [9:0] counter_H,
   output logic [9:0] counter_V,
   output logic       frame_start,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [5:0] rgb
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Decode boundaries, sized to the 10-bit counters.
   localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_END   = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END   = 10'(V_ACTIVE);
   localparam logic [9:0] H_SYN_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYN_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_SYN_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYN_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Coordinate counters and frame pulse
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       fs_q, fs_d;

   // Alignment pipeline; bit PIPE_LAT-1 of each vector is the output stage
   logic [PIPE_LAT-1:0] act_q, act_d;
   logic [PIPE_LAT-1:0] hsyn_q, hsyn_d;
   logic [PIPE_LAT-1:0] vsyn_q, vsyn_d;
   logic [5:0]          rgb_q, rgb_d;

   // Raw decodes of the current coordinate
   logic act_raw_s;
   logic hsyn_raw_s;
   logic vsyn_raw_s;

   // Next-state logic for the coordinate counters and the frame-wrap pulse.
   always_comb begin
      h_d  = h_q;
      v_d  = v_q;
      fs_d = 1'b0;
      if (h_q == H_LAST) begin
         h_d = 10'd0;
         if (v_q == V_LAST) begin
            v_d  = 10'd0;
            // The counters show (0,0) on the cycle after this edge.
            fs_d = 1'b1;
         end else begin
            v_d = v_q + 10'd1;
         end
      end else begin
         h_d = h_q + 10'd1;
      end
   end

   // Active-area and sync decodes taken straight from the registered counters.
   always_comb begin
      act_raw_s  = (h_q < H_ACT_END) && (v_q < V_ACT_END);
      hsyn_raw_s = (h_q >= H_SYN_FIRST) && (h_q <= H_SYN_LAST);
      vsyn_raw_s = (v_q >= V_SYN_FIRST) && (v_q <= V_SYN_LAST);
   end

   // Shift the decodes one stage per cycle; a single-stage pipe loads directly.
   generate
      if (PIPE_LAT == 1) begin : g_pipe_single
         assign act_d  = act_raw_s;
         assign hsyn_d = hsyn_raw_s;
         assign vsyn_d = vsyn_raw_s;
      end else begin : g_pipe_multi
         assign act_d  = {act_q[PIPE_LAT-2:0],  act_raw_s};
         assign hsyn_d = {hsyn_q[PIPE_LAT-2:0], hsyn_raw_s};
         assign vsyn_d = {vsyn_q[PIPE_LAT-2:0], vsyn_raw_s};
      end
   endgenerate

   // Pixel colour is chosen with the active flag entering the output stage, so
   // the colour sampled now belongs to the same coordinate as that flag.
   always_comb begin
      rgb_d = 6'd0;
      if (act_d[PIPE_LAT-1]) begin
         rgb_d = colour ? fg_rgb : bg_rgb;
      end else begin
         rgb_d = 6'd0;
      end
   end

   // Counter and frame-pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_q  <= 10'd0;
         v_q  <= 10'd0;
         fs_q <= 1'b0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         fs_q <= fs_d;
      end
   end

   // Alignment pipeline and colour output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         act_q  <= {PIPE_LAT{1'b0}};
         hsyn_q <= {PIPE_LAT{1'b0}};
         vsyn_q <= {PIPE_LAT{1'b0}};
         rgb_q  <= 6'd0;
      end else begin
         act_q  <= act_d;
         hsyn_q <= hsyn_d;
         vsyn_q <= vsyn_d;
         rgb_q  <= rgb_d;
      end
   end

   assign counter_H   = h_q;
   assign counter_V   = v_q;
   assign frame_start = fs_q;
   // Sync stages hold the active-high decode; reset value 0 gives idle-high sync.
   assign hsync       = ~hsyn_q[PIPE_LAT-1];
   assign vsync       = ~vsyn_q[PIPE_LAT-1];
   assign display_on  = act_q[PIPE_LAT-1];
   assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// Testbench for vga_timing_gen. Two instances run side by side:
//   A: default 640x480 timing, PIPE_LAT=3 (line-level behaviour, reset at H=300)
//   B: small 32x20 frame, PIPE_LAT=5 (frame wraps, vsync, reset during vsync)
// A driver pushes the expected post-edge state into a queue per instance; a
// monitor pops and compares one cycle after each rising edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       fs;
      logic       hs;
      logic       vs;
      logic       de;
      logic [5:0] rgb;
   } exp_t;

   logic       clk;
   logic       rst_a, rst_b;
   logic       colour;
   logic [5:0] fg_rgb, bg_rgb;

   logic [9:0] h_a, v_a, h_b, v_b;
   logic       fs_a, hs_a, vs_a, de_a, fs_b, hs_b, vs_b, de_b;
   logic [5:0] rgb_a, rgb_b;

   int checks = 0;
   int errors = 0;

   exp_t qa[$];
   exp_t qb[$];
   int   ka = 0;
   int   kb = 0;
   int   a_hold = 3;
   int   b_hold = 3;
   bit   a_rst_done = 1'b0;
   bit   b_rst_done = 1'b0;

   vga_timing_gen dut_a (
      .clk(clk), .reset(rst_a), .colour(colour), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
      .counter_H(h_a), .counter_V(v_a), .frame_start(fs_a),
      .hsync(hs_a), .vsync(vs_a), .display_on(de_a), .rgb(rgb_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
      .PIPE_LAT(5)
   ) dut_b (
      .clk(clk), .reset(rst_b), .colour(colour), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
      .counter_H(h_b), .counter_V(v_b), .frame_start(fs_b),
      .hsync(hs_b), .vsync(vs_b), .display_on(de_b), .rgb(rgb_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: after n edges since reset release the counters show pixel n of
   // an endless raster; the outputs describe pixel n-lat.
   function automatic exp_t model(input int ha, input int hf, input int hs, input int hb,
                                  input int va, input int vf, input int vs, input int vb,
                                  input int lat, input int n, input logic col,
                                  input logic [5:0] fg, input logic [5:0] bg);
      exp_t e;
      int ht, vt, p, ph, pv;
      ht   = ha + hf + hs + hb;
      vt   = va + vf + vs + vb;
      e.h  = 10'(n % ht);
      e.v  = 10'((n / ht) % vt);
      e.fs = (n > 0) && (n % (ht * vt) == 0);
      p    = n - lat;
      if (p < 0) begin
         e.hs  = 1'b1;
         e.vs  = 1'b1;
         e.de  = 1'b0;
         e.rgb = 6'd0;
      end else begin
         ph    = p % ht;
         pv    = (p / ht) % vt;
         e.de  = (ph < ha) && (pv < va);
         e.hs  = !((ph >= ha + hf) && (ph < ha + hf + hs));
         e.vs  = !((pv >= va + vf) && (pv < va + vf + vs));
         e.rgb = e.de ? (col ? fg : bg) : 6'd0;
      end
      return e;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic cmp(input string tag, input exp_t e, input logic [9:0] h, input logic [9:0] v,
                      input logic fs, input logic hs, input logic vs, input logic de,
                      input logic [5:0] rgb);
      check({tag, ".counter_H"},   32'(h),   32'(e.h));
      check({tag, ".counter_V"},   32'(v),   32'(e.v));
      check({tag, ".frame_start"}, 32'(fs),  32'(e.fs));
      check({tag, ".hsync"},       32'(hs),  32'(e.hs));
      check({tag, ".vsync"},       32'(vs),  32'(e.vs));
      check({tag, ".display_on"},  32'(de),  32'(e.de));
      check({tag, ".rgb"},         32'(rgb), 32'(e.rgb));
   endtask

   task automatic check_rst_a(input string nm);
      exp_t e;
      e = '{h: 10'd0, v: 10'd0, fs: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 6'd0};
      cmp(nm, e, h_a, v_a, fs_a, hs_a, vs_a, de_a, rgb_a);
   endtask

   task automatic check_rst_b(input string nm);
      exp_t e;
      e = '{h: 10'd0, v: 10'd0, fs: 1'b0, hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 6'd0};
      cmp(nm, e, h_b, v_b, fs_b, hs_b, vs_b, de_b, rgb_b);
   endtask

   // One pixel cycle: handle releases, drive inputs, push expectations, and
   // plant mid-cycle resets at the chosen coordinates.
   task automatic step();
      int pa;
      @(negedge clk);
      if (!rst_a) begin
         if (a_hold == 0) begin
            check_rst_a("A.rst_hold");
            rst_a = 1'b1;
            ka    = 0;
         end else begin
            a_hold--;
         end
      end
      if (!rst_b) begin
         if (b_hold == 0) begin
            check_rst_b("B.rst_hold");
            rst_b = 1'b1;
            kb    = 0;
         end else begin
            b_hold--;
         end
      end

      // Pixel of instance A whose colour is sampled at the coming edge.
      pa = ka + 1 - 3;
      if (!a_rst_done || ka < 1600) begin
         colour = 1'($urandom_range(0, 1));
         fg_rgb = 6'($urandom);
         bg_rgb = 6'($urandom);
      end else if (ka < 3200) begin
         fg_rgb = 6'h3F;
         bg_rgb = 6'h05;
         colour = (pa >= 0 && (pa % 800) >= 600) ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
         fg_rgb = 6'h3F;
         bg_rgb = 6'h05;
         colour = (pa >= 0 && (pa % 800) == 100) ? 1'b1 : 1'b0;
      end

      if (rst_a) begin
         ka++;
         qa.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 3, ka, colour, fg_rgb, bg_rgb));
      end
      if (rst_b) begin
         kb++;
         qb.push_back(model(20, 3, 5, 4, 12, 2, 3, 3, 5, kb, colour, fg_rgb, bg_rgb));
      end

      @(posedge clk);
      #3;
      if (rst_a && !a_rst_done && ka == 300) begin
         rst_a      = 1'b0;
         a_rst_done = 1'b1;
         a_hold     = 5;
         #1;
         check_rst_a("A.rst_midline");
      end
      if (rst_b && !b_rst_done && kb > 1300 && (kb % 640) == 490) begin
         rst_b      = 1'b0;
         b_rst_done = 1'b1;
         b_hold     = 4;
         #1;
         check_rst_b("B.rst_vsync");
      end
   endtask

   // Monitor: compare each instance one time unit after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp("A", e, h_a, v_a, fs_a, hs_a, vs_a, de_a, rgb_a);
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp("B", e, h_b, v_b, fs_b, hs_b, vs_b, de_b, rgb_b);
         end
      end
   end

   // Independent pulse-width check: every hsync low run on A lasts 96 cycles.
   initial begin
      int run;
      run = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_a) begin
            run = 0;
         end else if (!hs_a) begin
            run++;
         end else if (run > 0) begin
            check("A.hsync_width", 32'(run), 32'd96);
            run = 0;
         end
      end
   end

   // Independent period check: frame_start pulses on B are 640 cycles apart.
   initial begin
      int cnt;
      bit seen;
      cnt  = 0;
      seen = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_b) begin
            seen = 1'b0;
            cnt  = 0;
         end else begin
            cnt++;
            if (fs_b) begin
               if (seen) begin
                  check("B.frame_period", 32'(cnt), 32'd640);
               end
               seen = 1'b1;
               cnt  = 0;
            end
         end
      end
   end

   initial begin
      rst_a  = 1'b0;
      rst_b  = 1'b0;
      colour = 1'b0;
      fg_rgb = 6'd0;
      bg_rgb = 6'd0;
      #1;
      check_rst_a("A.rst_initial");
      check_rst_b("B.rst_initial");
      repeat (5120) step();
      @(posedge clk);
      #2;
      check("A.queue_drained", 32'(qa.size()), 32'd0);
      check("B.queue_drained", 32'(qb.size()), 32'd0);
      check("A.reset_applied", 32'(a_rst_done), 32'd1);
      check("B.reset_applied", 32'(b_rst_done), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing master for the display path. Generates the `counter_H`/`counter_V` pixel coordinates consumed by the frame buffer controller, and samples that controller's 1-bit `colour` result. Delays sync and blanking by the controller's fixed pipeline latency so sync, blank and pixel data leave the chip aligned. Drives 2-bit-per-channel RGB plus active-low HSYNC/VSYNC for the VGA PMOD.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_LAT, 3, cycles from a coordinate appearing on the counters to its `colour` being sampled; legal range 1..8

Ports:
- clk  in  1  pixel clock, one pixel per cycle, 25.175 MHz nominal
- reset  in  1  asynchronous, active-low
- colour  in  1  frame buffer pixel: 0 = background, 1 = foreground
- fg_rgb  in  6  foreground colour {R[1:0],G[1:0],B[1:0]}
- bg_rgb  in  6  background colour, same packing
- counter_H  out  10  current horizontal coordinate, 0..H_TOTAL-1
- counter_V  out  10  current vertical coordinate, 0..V_TOTAL-1
- frame_start  out  1  one-cycle pulse on frame wrap
- hsync  out  1  active-low, pipeline-aligned
- vsync  out  1  active-low, pipeline-aligned
- display_on  out  1  active-area flag, pipeline-aligned
- rgb  out  6  {R,G,B}, pipeline-aligned; 0 when blanked

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters:
  - `counter_H` increments every cycle. At H_TOTAL-1 it wraps to 0 and `counter_V` increments.
  - `counter_V` wraps to 0 from V_TOTAL-1, only on an H wrap.
  - Both are registered outputs.
- Raw decodes, combinational from the registered counters:
  - h_act = H < H_ACTIVE
  - v_act = V < V_ACTIVE
  - h_syn = H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751)
  - v_syn = V in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491)
- Alignment pipeline: {h_act&v_act, h_syn, v_syn} pass through a PIPE_LAT-stage shift register. The final stage is the output register.
  - hsync = ~stage_h_syn
  - vsync = ~stage_v_syn
  - display_on = stage_act
- rgb is registered at the same edge as the final shift stage:
  - active: colour ? fg_rgb : bg_rgb
  - blanked: 6'b0
  - `colour` is ignored while blanked.
- frame_start:
  - registered; high for exactly the one cycle in which the counters read (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1);
  - not asserted in the first cycle after reset release.
- fg_rgb/bg_rgb are sampled every cycle; no holding.

## Timing
- Reset (asynchronous assert, any cycle, including mid-frame), all outputs and pipeline stages take their reset values immediately:
  - counter_H = 0, counter_V = 0
  - hsync = 1, vsync = 1, display_on = 0
  - rgb = 0, frame_start = 0
- Release: the first rising edge after deassertion advances counter_H to 1.
- Latency: if the counters take coordinate (h,v) at edge E, then:
  - `colour` for (h,v) is sampled at edge E+PIPE_LAT;
  - hsync/vsync/display_on/rgb for (h,v) appear after edge E+PIPE_LAT.
- Pulse widths:
  - hsync low for exactly H_SYNC consecutive cycles per line;
  - vsync low for exactly V_SYNC×H_TOTAL cycles, starting at the line boundary plus PIPE_LAT.
- Frame period: exactly H_TOTAL×V_TOTAL = 420000 cycles, measured between frame_start pulses.
- Simultaneous H and V wrap: a single cycle moves (799,524) to (0,0) and asserts frame_start.
- No back-pressure exists; the counters never stall.

## Test plan
- Reset with reset=0 for 5 cycles mid-line (H=300) → immediately counter_H=0, counter_V=0, hsync=1, vsync=1, rgb=0, display_on=0; after release, counter_H=1 at first edge.
- Run one line with PIPE_LAT=3 → counter_H 799→0 and counter_V +1 on the same edge; hsync falls 3 cycles after counter_H=656 and stays low exactly 96 cycles.
- Run full frame → vsync low exactly 1600 cycles, falling 3 cycles after (H=0,V=490); frame_start pulses once, consecutive pulses 420000 cycles apart, none right after reset.
- colour=1, fg_rgb=6'h3F, bg_rgb=6'h05 in active area → rgb=6'h3F; colour=0 → rgb=6'h05; at H=640..799 or V≥480, rgb=0 even with colour=1.
- Alignment: drive colour=1 only when the coordinate 3 cycles earlier was H=100 (else 0) → rgb=fg for exactly one cycle, coincident with the pipeline-aligned pixel 100 slot.
- Reset asserted mid-frame at V=490 during vsync → vsync returns to 1 immediately, and the counter restarts a fresh frame from (0,0).
